// File: rtl/fixed_sub_arbiter_if.sv
// fixed_sub_arbiter_if: requester, subtractor and result signals of the shared subtractor arbiter
interface fixed_sub_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]       req_vld;
  logic [N_REQ*WIDTH-1:0] req_a_dat;
  logic [N_REQ*WIDTH-1:0] req_b_dat;
  logic [N_REQ-1:0]       req_rdy;
  logic                   sub_vld;
  logic [WIDTH-1:0]       sub_a_dat;
  logic [WIDTH-1:0]       sub_b_dat;
  logic [WIDTH-1:0]       sub_s_dat;
  logic                   res_vld;
  logic [WIDTH-1:0]       res_dat;
  logic [ID_W-1:0]        res_id;
  logic                   res_rdy;
  modport slave (
    input  req_vld, req_a_dat, req_b_dat, sub_s_dat, res_rdy,
    output req_rdy, sub_vld, sub_a_dat, sub_b_dat, res_vld, res_dat, res_id
  );
  modport master (
    output req_vld, req_a_dat, req_b_dat, sub_s_dat, res_rdy,
    input  req_rdy, sub_vld, sub_a_dat, sub_b_dat, res_vld, res_dat, res_id
  );
endinterface

// File: rtl/fixed_sub_arbiter.sv
// fixed_sub_arbiter: round-robin sharing of a fixed-latency subtractor with tagged, credit-protected result FIFO
module fixed_sub_arbiter #(
  parameter int WIDTH      = 32,
  parameter int N_REQ      = 4,
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input logic clk,
  input logic rst,
  fixed_sub_arbiter_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic             issue;
  logic [CW-1:0]    credits;
  logic [LATENCY-1:0] tag_vld;
  logic [ID_W-1:0]  tag_id [LATENCY];
  logic [WIDTH-1:0] fifo_dat [FIFO_DEPTH];
  logic [ID_W-1:0]  fifo_id [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && bus.req_vld[(int'(rr_ptr) + k) % N_REQ]) begin
        winner = ID_W'((int'(rr_ptr) + k) % N_REQ);
        found  = 1'b1;
      end
    end
  end
  // Credits cover both FIFO entries and in-flight ops, since the subtractor cannot stall
  assign issue         = found && credits != '0 && !rst;
  assign bus.req_rdy   = issue ? N_REQ'(1) << winner : '0;
  assign bus.sub_vld   = issue;
  assign bus.sub_a_dat = issue ? bus.req_a_dat[int'(winner)*WIDTH +: WIDTH] : '0;
  assign bus.sub_b_dat = issue ? bus.req_b_dat[int'(winner)*WIDTH +: WIDTH] : '0;
  assign push          = tag_vld[LATENCY-1];
  assign pop           = bus.res_vld && bus.res_rdy;
  assign bus.res_vld   = count != '0;
  assign bus.res_dat   = fifo_dat[rd_ptr];
  assign bus.res_id    = fifo_id[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      credits <= CW'(FIFO_DEPTH);
    end else begin
      rr_ptr  <= issue ? (winner == ID_W'(N_REQ - 1) ? '0 : winner + 1'b1) : rr_ptr;
      credits <= credits + CW'(pop) - CW'(issue);
    end
  end
  always_ff @(posedge clk) begin
    tag_id[0] <= winner;
    for (int s = 1; s < LATENCY; s++) tag_id[s] <= tag_id[s-1];
    if (rst) tag_vld <= '0;
    else begin
      tag_vld[0] <= issue;
      for (int s = 1; s < LATENCY; s++) tag_vld[s] <= tag_vld[s-1];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_dat[wr_ptr] <= bus.sub_s_dat;
        fifo_id[wr_ptr]  <= tag_id[LATENCY-1];
        wr_ptr           <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  no_push_at_full: assert property (@(posedge clk) disable iff (rst) !(push && !pop && count == CW'(FIFO_DEPTH)));
  no_pop_at_empty: assert property (@(posedge clk) disable iff (rst) !(pop && count == '0));
endmodule

// File: tb/tb_fixed_sub_arbiter.sv
// tb_fixed_sub_arbiter: directed checks of grant order, latency, backpressure and reset flush
module tb_fixed_sub_arbiter;
  localparam int WIDTH = 32, N_REQ = 4, LATENCY = 2, FIFO_DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] pipe [LATENCY];
  logic [31:0] a_tab [4] = '{32'h00000010, 32'h12345678, 32'h00000005, 32'h80000000};
  logic [31:0] b_tab [4] = '{32'h00000003, 32'h02345670, 32'h00000009, 32'h00000001};
  logic [31:0] exp_diff [4] = '{32'h0000000D, 32'h10000008, 32'hFFFFFFFC, 32'h7FFFFFFF};
  fixed_sub_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();
  fixed_sub_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    pipe[0] <= bus.sub_a_dat - bus.sub_b_dat;
    for (int s = 1; s < LATENCY; s++) pipe[s] <= pipe[s-1];
  end
  assign bus.sub_s_dat = pipe[LATENCY-1];
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic load_table();
    for (int i = 0; i < N_REQ; i++) begin
      bus.req_a_dat[i*WIDTH +: WIDTH] = a_tab[i];
      bus.req_b_dat[i*WIDTH +: WIDTH] = b_tab[i];
    end
  endtask
  initial begin
    bus.req_vld = '0;
    bus.req_a_dat = '0;
    bus.req_b_dat = '0;
    bus.res_rdy = 1'b0;
    cyc();
    bus.req_vld = 4'b1111;
    cyc();
    #1;
    chk("rst_req_rdy", 64'(bus.req_rdy), 64'h0);
    chk("rst_sub_vld", 64'(bus.sub_vld), 64'h0);
    chk("rst_res_vld", 64'(bus.res_vld), 64'h0);
    chk("rst_credits", 64'(dut.credits), 64'd4);
    bus.req_vld = '0;
    rst = 1'b0;
    bus.req_a_dat[2*WIDTH +: WIDTH] = 32'h00000010;
    bus.req_b_dat[2*WIDTH +: WIDTH] = 32'h00000003;
    bus.req_vld = 4'b0100;
    #1;
    chk("single_rdy", 64'(bus.req_rdy), 64'h4);
    chk("single_sub_vld", 64'(bus.sub_vld), 64'h1);
    chk("single_sub_a", 64'(bus.sub_a_dat), 64'h10);
    chk("single_sub_b", 64'(bus.sub_b_dat), 64'h3);
    cyc();
    bus.req_vld = '0;
    #1;
    chk("single_rdy_drop", 64'(bus.req_rdy), 64'h0);
    chk("single_sub_a_idle", 64'(bus.sub_a_dat), 64'h0);
    chk("single_lat1", 64'(bus.res_vld), 64'h0);
    cyc();
    chk("single_lat2", 64'(bus.res_vld), 64'h0);
    cyc();
    chk("single_res_vld", 64'(bus.res_vld), 64'h1);
    chk("single_res_dat", 64'(bus.res_dat), 64'h0000000D);
    chk("single_res_id", 64'(bus.res_id), 64'd2);
    bus.res_rdy = 1'b1;
    cyc();
    bus.res_rdy = 1'b0;
    #1;
    chk("single_popped", 64'(bus.res_vld), 64'h0);
    chk("single_credits", 64'(dut.credits), 64'd4);
    bus.req_a_dat[0 +: WIDTH] = 32'h00000000;
    bus.req_b_dat[0 +: WIDTH] = 32'h00000001;
    bus.req_vld = 4'b0001;
    #1;
    chk("wrap_rdy", 64'(bus.req_rdy), 64'h1);
    cyc();
    bus.req_vld = '0;
    cyc();
    cyc();
    chk("wrap_res_vld", 64'(bus.res_vld), 64'h1);
    chk("wrap_res_dat", 64'(bus.res_dat), 64'hFFFFFFFF);
    chk("wrap_res_id", 64'(bus.res_id), 64'd0);
    bus.res_rdy = 1'b1;
    cyc();
    bus.res_rdy = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    load_table();
    bus.res_rdy = 1'b1;
    bus.req_vld = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("rr_grant", 64'(bus.req_rdy), 64'(1) << (k % 4));
      chk("rr_sub_a", 64'(bus.sub_a_dat), 64'(a_tab[k % 4]));
      if (k < 3) chk("rr_fill", 64'(bus.res_vld), 64'h0);
      else begin
        chk("rr_res_vld", 64'(bus.res_vld), 64'h1);
        chk("rr_res_id", 64'(bus.res_id), 64'((k - 3) % 4));
        chk("rr_res_dat", 64'(bus.res_dat), 64'(exp_diff[(k - 3) % 4]));
        chk("rr_credits", 64'(dut.credits), 64'd1);
        chk("rr_count", 64'(dut.count), 64'd1);
      end
      cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.res_rdy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("bp_grant", 64'(bus.req_rdy), k < 4 ? 64'(1) << k : 64'h0);
      cyc();
    end
    chk("bp_count", 64'(dut.count), 64'd4);
    chk("bp_credits", 64'(dut.credits), 64'd0);
    chk("bp_res_id", 64'(bus.res_id), 64'd0);
    chk("bp_res_dat", 64'(bus.res_dat), 64'(exp_diff[0]));
    bus.res_rdy = 1'b1;
    #1;
    chk("bp_pop_same_cycle", 64'(bus.req_rdy), 64'h0);
    cyc();
    bus.res_rdy = 1'b0;
    #1;
    chk("bp_one_issue", 64'(bus.req_rdy), 64'h1);
    chk("bp_head_next", 64'(bus.res_id), 64'd1);
    cyc();
    chk("bp_stall_again", 64'(bus.req_rdy), 64'h0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) cyc();
    chk("mid_count", 64'(dut.count), 64'd2);
    chk("mid_inflight", 64'(dut.tag_vld), 64'h3);
    rst = 1'b1;
    cyc();
    chk("mid_res_vld", 64'(bus.res_vld), 64'h0);
    chk("mid_req_rdy", 64'(bus.req_rdy), 64'h0);
    chk("mid_credits", 64'(dut.credits), 64'd4);
    rst = 1'b0;
    bus.req_vld = '0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("mid_no_stale", 64'(bus.res_vld), 64'h0);
    end
    bus.req_vld = 4'b1111;
    #1;
    chk("mid_first_grant", 64'(bus.req_rdy), 64'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
